// File: rtl/asicfreq_scheduler.sv
// Sweeps the shared asicfreq edge counter across NCH signal-under-test inputs: select, settle, clear, gate, wait, report.
// Define ASICFREQ_OVF_SAT_EN to saturate res_value to all ones when the counter reports a wrap.
`timescale 1ns/1ps
module asicfreq_scheduler #(
    parameter int NCH      = 4,
    parameter int CH_W     = 2,
    parameter int DW       = 32,
    parameter int GATE_W   = 24,
    parameter int SETTLE   = 4,
    parameter int SYNC_LAT = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cfg_en,
    input  logic              cfg_cont,
    input  logic              cfg_start,
    input  logic [NCH-1:0]    cfg_mask,
    input  logic [GATE_W-1:0] cfg_gate,
    output logic              busy,
    output logic [CH_W-1:0]   cnt_sel,
    output logic              cnt_clear,
    output logic              cnt_gate,
    input  logic [DW-1:0]     cnt_value,
    input  logic              cnt_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_addr,
    output logic [DW-1:0]     res_value,
    output logic              res_ovf,
    output logic              sweep_done
);

    localparam int PMAX = (SETTLE > SYNC_LAT) ? SETTLE : SYNC_LAT;
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {
        IDLE, SELECT, CLEAR, GATE, WAIT, REPORT
    } state_t;

    state_t            state;
    logic [NCH-1:0]    mask_q;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] gate_cnt;
    logic [PW-1:0]     ph_cnt;

    logic [CH_W-1:0]   lo_ch;
    logic [CH_W-1:0]   nxt_ch;
    logic              nxt_found;
    logic [DW-1:0]     cap_value;

    // lowest channel of the incoming mask, and the next latched channel above the current one
    always_comb begin
        lo_ch     = '0;
        nxt_ch    = '0;
        nxt_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cfg_mask[i])
                lo_ch = CH_W'(i);
            if (mask_q[i] && (i > int'(cnt_sel))) begin
                nxt_ch    = CH_W'(i);
                nxt_found = 1'b1;
            end
        end
    end

`ifdef ASICFREQ_OVF_SAT_EN
    assign cap_value = cnt_ovf ? {DW{1'b1}} : cnt_value;
`else
    assign cap_value = cnt_value;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            mask_q     <= '0;
            gate_q     <= '0;
            gate_cnt   <= '0;
            ph_cnt     <= '0;
            busy       <= 1'b0;
            cnt_sel    <= '0;
            cnt_clear  <= 1'b0;
            cnt_gate   <= 1'b0;
            res_valid  <= 1'b0;
            res_addr   <= '0;
            res_value  <= '0;
            res_ovf    <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (!cfg_en) begin
                // abort: drop any in-flight measurement or pending result
                state     <= IDLE;
                busy      <= 1'b0;
                cnt_sel   <= '0;
                cnt_clear <= 1'b0;
                cnt_gate  <= 1'b0;
                res_valid <= 1'b0;
                res_addr  <= '0;
                res_value <= '0;
                res_ovf   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cfg_start || cfg_cont) begin
                            mask_q <= cfg_mask;
                            if (cfg_mask == '0) begin
                                sweep_done <= 1'b1;
                            end else begin
                                state   <= SELECT;
                                busy    <= 1'b1;
                                cnt_sel <= lo_ch;
                                ph_cnt  <= '0;
                            end
                        end
                    end
                    SELECT: begin
                        if (ph_cnt == PW'(SETTLE - 1)) begin
                            state     <= CLEAR;
                            cnt_clear <= 1'b1;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    CLEAR: begin
                        state     <= GATE;
                        cnt_clear <= 1'b0;
                        cnt_gate  <= 1'b1;
                        gate_q    <= cfg_gate;
                        gate_cnt  <= GATE_W'(1);
                    end
                    GATE: begin
                        // a zero gate length still opens a one-cycle window
                        if (gate_cnt >= gate_q) begin
                            state    <= WAIT;
                            cnt_gate <= 1'b0;
                            ph_cnt   <= '0;
                        end else begin
                            gate_cnt <= gate_cnt + 1'b1;
                        end
                    end
                    WAIT: begin
                        if (ph_cnt == PW'(SYNC_LAT - 1)) begin
                            state     <= REPORT;
                            res_valid <= 1'b1;
                            res_addr  <= cnt_sel;
                            res_value <= cap_value;
                            res_ovf   <= cnt_ovf;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    REPORT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            ph_cnt    <= '0;
                            if (nxt_found) begin
                                state   <= SELECT;
                                cnt_sel <= nxt_ch;
                            end else begin
                                sweep_done <= 1'b1;
                                if (cfg_cont && (cfg_mask != '0)) begin
                                    mask_q  <= cfg_mask;
                                    state   <= SELECT;
                                    cnt_sel <= lo_ch;
                                end else begin
                                    mask_q <= cfg_cont ? cfg_mask : mask_q;
                                    state  <= IDLE;
                                    busy   <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_asicfreq_scheduler.sv
// Randomized bench for asicfreq_scheduler: a weighted counter model feeds cnt_value, a per-sweep reference predicts results and timing.
`timescale 1ns/1ps
module tb_asicfreq_scheduler;

    localparam int NCH      = 4;
    localparam int CH_W     = 2;
    localparam int DW       = 32;
    localparam int GATE_W   = 24;
    localparam int SETTLE   = 4;
    localparam int SYNC_LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_en;
    logic              cfg_cont;
    logic              cfg_start;
    logic [NCH-1:0]    cfg_mask;
    logic [GATE_W-1:0] cfg_gate;
    logic              busy;
    logic [CH_W-1:0]   cnt_sel;
    logic              cnt_clear;
    logic              cnt_gate;
    logic [DW-1:0]     cnt_value;
    logic              cnt_ovf;
    logic              res_valid;
    logic              res_ready;
    logic [CH_W-1:0]   res_addr;
    logic [DW-1:0]     res_value;
    logic              res_ovf;
    logic              sweep_done;

    asicfreq_scheduler #(
        .NCH(NCH), .CH_W(CH_W), .DW(DW), .GATE_W(GATE_W),
        .SETTLE(SETTLE), .SYNC_LAT(SYNC_LAT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cfg_en(cfg_en), .cfg_cont(cfg_cont), .cfg_start(cfg_start),
        .cfg_mask(cfg_mask), .cfg_gate(cfg_gate),
        .busy(busy), .cnt_sel(cnt_sel), .cnt_clear(cnt_clear), .cnt_gate(cnt_gate),
        .cnt_value(cnt_value), .cnt_ovf(cnt_ovf),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_addr(res_addr), .res_value(res_value), .res_ovf(res_ovf),
        .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int stall_n = 0;
    int busy_cyc = 0;
    bit force_ovf = 1'b0;

    // channel k behaves like a SUT with k+1 edges per clock
    logic [DW-1:0] cnt_m = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_clear) cnt_m <= '0;
        else if (cnt_gate) cnt_m <= cnt_m + DW'(cnt_sel) + 1;
    end
    assign cnt_value = force_ovf ? 32'h5 : cnt_m;
    assign cnt_ovf   = force_ovf;

    int          got_a[$];
    logic [31:0] got_v[$];
    bit          got_o[$];
    bit          got_s[$];
    int          done_q[$];
    int          gates[$];

    // monitor + ready driver, all at the falling edge
    initial begin
        int glen, vcnt;
        bit hold, unstab;
        logic [CH_W+DW:0] snap;
        glen = 0; vcnt = 0; hold = 0; unstab = 0; snap = '0;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (sweep_done) done_q.push_back(cyc);
            if (cnt_gate) glen++;
            else if (glen != 0) begin gates.push_back(glen); glen = 0; end
            if (stall_n == 0) res_ready = 1'b1;
            else if (res_valid) begin res_ready = (vcnt >= stall_n); vcnt++; end
            else begin res_ready = 1'b0; vcnt = 0; end
            if (res_valid) begin
                if (!hold) begin snap = {res_addr, res_value, res_ovf}; hold = 1; unstab = 0; end
                else if ({res_addr, res_value, res_ovf} != snap) unstab = 1;
                if (res_ready) begin
                    got_a.push_back(int'(res_addr));
                    got_v.push_back(res_value);
                    got_o.push_back(res_ovf);
                    got_s.push_back(!unstab);
                    hold = 0;
                end
            end else hold = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_val(input int ch, input int ge);
        if (force_ovf) begin
`ifdef ASICFREQ_OVF_SAT_EN
            return 32'hFFFF_FFFF;
`else
            return 32'h5;
`endif
        end
        return 32'((ch + 1) * ge);
    endfunction

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic run_sweep(input logic [NCH-1:0] m, input int g, input int st, input bit lat);
        int s, n, ln, ge, br, bd, bg, bb, idx;
        stall_n = st;
        tick();
        br = got_a.size(); bd = done_q.size(); bg = gates.size(); bb = busy_cyc;
        cfg_mask = m; cfg_gate = GATE_W'(g); cfg_start = 1'b1; s = cyc;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 4000 && done_q.size() == bd; k++) tick();
        chk("done_seen", 64'(done_q.size() > bd), 64'd1);
        repeat (3) tick();
        chk("one_done", 64'(done_q.size() - bd), 64'd1);
        chk("idle_after", 64'(busy), 64'd0);
        ge = (g == 0) ? 1 : g;
        ln = SETTLE + 1 + ge + SYNC_LAT + 1;
        n  = $countones(m);
        chk("n_res", 64'(got_a.size() - br), 64'(n));
        idx = br;
        for (int i = 0; i < NCH; i++) begin
            if (m[i] && idx < got_a.size()) begin
                chk("res_addr", 64'(got_a[idx]), 64'(i));
                chk("res_value", 64'(got_v[idx]), 64'(exp_val(i, ge)));
                chk("res_ovf", 64'(got_o[idx]), 64'(force_ovf));
                chk("res_stable", 64'(got_s[idx]), 64'd1);
                idx++;
            end
        end
        for (int j = bg; j < gates.size(); j++) chk("gate_len", 64'(gates[j]), 64'(ge));
        if (lat && done_q.size() > bd) chk("latency", 64'(done_q[bd] - s), 64'(n * ln + 1));
        if (m == '0) chk("mask0_busy", 64'(busy_cyc - bb), 64'd0);
    endtask

    initial begin
        int s, bd, br, bg, lc, k;
        rst = 1'b1; cfg_en = 1'b1; cfg_cont = 1'b0; cfg_start = 1'b0;
        cfg_mask = '0; cfg_gate = '0;
        repeat (3) tick();
        chk("reset", {busy, cnt_sel, cnt_clear, cnt_gate, res_valid, res_addr, res_ovf, sweep_done, res_value},
            '0);
        rst = 1'b0;
        tick();

        // full sweep, all channels
        run_sweep(4'b1111, 100, 0, 1);
        // stalled consumer, sparse mask
        run_sweep(4'b0101, 10, 20, 0);
        // empty mask
        run_sweep(4'b0000, 7, 0, 1);

        // continuous sweeps on channel 1 with a zero gate
        stall_n = 0;
        tick();
        bd = done_q.size(); br = got_a.size(); bg = gates.size();
        lc = SETTLE + 1 + 1 + SYNC_LAT + 1;
        cfg_mask = 4'b0010; cfg_gate = '0; cfg_cont = 1'b1; s = cyc;
        for (k = 0; k < 2000 && done_q.size() < bd + 4; k++) tick();
        chk("cont_done", 64'(done_q.size() >= bd + 4), 64'd1);
        cfg_cont = 1'b0;
        for (k = 0; k < 200 && busy; k++) tick();
        chk("cont_stop", 64'(busy), 64'd0);
        if (done_q.size() >= bd + 4) begin
            chk("cont_first", 64'(done_q[bd] - s), 64'(lc + 1));
            for (int j = 1; j < 4; j++)
                chk("cont_period", 64'(done_q[bd + j] - done_q[bd + j - 1]), 64'(lc));
        end
        for (int j = br; j < got_a.size(); j++) begin
            chk("cont_addr", 64'(got_a[j]), 64'd1);
            chk("cont_value", 64'(got_v[j]), 64'd2);
        end
        for (int j = bg; j < gates.size(); j++) chk("cont_gate", 64'(gates[j]), 64'd1);

        // abort in the middle of a gate window
        tick();
        br = got_a.size();
        cfg_mask = 4'b1111; cfg_gate = 24'd50; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (k = 0; k < 500 && !cnt_gate; k++) tick();
        chk("abort_gate_seen", 64'(cnt_gate), 64'd1);
        repeat (5) tick();
        cfg_en = 1'b0;
        tick();
        chk("abort_state", {61'd0, busy, cnt_gate, res_valid}, 64'd0);
        chk("abort_nores", 64'(got_a.size() - br), 64'd0);
        repeat (3) tick();
        cfg_en = 1'b1;
        run_sweep(4'b1011, 12, 0, 1);

        // counter overflow
        force_ovf = 1'b1;
        run_sweep(4'b0001, 3, 0, 1);
        force_ovf = 1'b0;

        // randomized sweeps
        for (int r = 0; r < 10; r++) begin
            int st;
            st = (r % 2 == 0) ? 0 : int'($urandom_range(1, 5));
            run_sweep(NCH'($urandom_range(0, 15)), int'($urandom_range(0, 30)), st, st == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
